// File: rtl/star_route_compute_pipe.sv
// star_route_compute_pipe: wormhole route-compute stage with one-flit registered output,
// unroutable/orphan discard with error pulses, and a delivered-packet counter.
module star_route_compute_pipe #(
    parameter int NUM_PORTS = 10,
    parameter int FLIT_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 1,
    parameter int CNT_W     = 16,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [FLIT_W-1:0]    in_flit,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [FLIT_W-1:0]    out_flit,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [NUM_PORTS-1:0] port_sel,
    output logic [PW-1:0]        port_num,
    output logic                 err_unroutable,
    output logic                 err_orphan,
    output logic [CNT_W-1:0]     pkt_count
);
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
    state_t state, state_next;
    logic head, tail, routable, acc, xfer, load, fwd;
    logic [ADDR_W:0] idx_full;
    assign head = in_flit[FLIT_W-1];
    assign tail = in_flit[FLIT_W-2];
    // one extra bit so destinations below BASE_ADDR show up as negative, not wrapped
    assign idx_full = {1'b0, in_flit[ADDR_W-1:0]} - (ADDR_W+1)'(BASE_ADDR);
    assign routable = ~idx_full[ADDR_W] & (idx_full < (ADDR_W+1)'(NUM_PORTS));
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (acc) begin
            if (state == IDLE) state_next = (head & ~tail) ? (routable ? BUSY : DROP) : IDLE;
            else if (tail)     state_next = IDLE;
        end
    end
    always_comb begin
        in_ready = (state == DROP) | ~out_valid | out_ready[port_num];
        acc      = in_valid & in_ready;
        xfer     = out_valid & out_ready[port_num];
        load     = acc & (state == IDLE) & head & routable;
        fwd      = load | (acc & (state == BUSY));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_flit       <= '0;
            port_sel       <= '0;
            port_num       <= '0;
            err_unroutable <= 1'b0;
            err_orphan     <= 1'b0;
            pkt_count      <= '0;
        end else begin
            out_valid      <= fwd ? 1'b1 : (xfer ? 1'b0 : out_valid);
            out_flit       <= fwd ? in_flit : out_flit;
            port_sel       <= load ? NUM_PORTS'(1) << idx_full[PW-1:0] :
                              (xfer & out_flit[FLIT_W-2]) ? '0 : port_sel;
            port_num       <= load ? idx_full[PW-1:0] :
                              (xfer & out_flit[FLIT_W-2]) ? '0 : port_num;
            err_unroutable <= acc & (state == IDLE) & head & ~routable;
            err_orphan     <= acc & (state == IDLE) & ~head;
            pkt_count      <= pkt_count + CNT_W'(xfer & out_flit[FLIT_W-2]);
        end
    end
endmodule

// File: doc/star_route_compute_pipe.md
Name: star_route_compute_pipe

Overview:
- Parametrised, pipelined successor to the star-router route-compute stage.
- Decodes the destination field of each head flit into a one-hot output-port select, then locks that select for the rest of the packet (wormhole) until the tail flit leaves.
- Provides a one-flit registered output stage with valid/ready handshake per output port.
- Discards unroutable packets and orphan flits, flags each with an error pulse, and counts forwarded packets.

Parameters:
- NUM_PORTS, 10, number of output ports; port i serves destination address BASE_ADDR+i.
- FLIT_W, 8, flit width. Bit FLIT_W-1 = head marker, bit FLIT_W-2 = tail marker.
- ADDR_W, 6, destination field width, located at flit[ADDR_W-1:0]. Must be ≤ FLIT_W-2.
- BASE_ADDR, 1, destination address mapped to port 0.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input flit valid.
- in_flit  in  FLIT_W  input flit.
- in_ready  out  1  block accepts in_flit this cycle.
- out_valid  out  1  registered flit available.
- out_flit  out  FLIT_W  registered flit, unmodified.
- out_ready  in  NUM_PORTS  per-port downstream ready.
- port_sel  out  NUM_PORTS  one-hot select for the current packet. All zero when no packet is routed.
- port_num  out  $clog2(NUM_PORTS)  binary index matching port_sel.
- err_unroutable  out  1  one-cycle pulse when a head flit's destination is out of range.
- err_orphan  out  1  one-cycle pulse when a non-head flit arrives in IDLE.
- pkt_count  out  CNT_W  count of tail flits delivered; wraps at 2^CNT_W.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, out_valid=0, out_flit=0, port_sel=0, port_num=0, err_unroutable=0, err_orphan=0, pkt_count=0. Reset mid-packet abandons the packet; any held output flit is lost.
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready[port_num].
  - in_ready = (state==DROP) | ~out_valid | out_ready[port_num]. Combinational pass-through, so a full stage can accept a new flit in the same cycle it drains.
- Latency: an accepted flit appears on out_flit the next cycle. Sustained throughput is 1 flit/cycle when the selected port is ready.
- Destination decode: dest = in_flit[ADDR_W-1:0]. Routable iff BASE_ADDR ≤ dest ≤ BASE_ADDR+NUM_PORTS-1. Index = dest−BASE_ADDR, computed at ADDR_W+1 bits so there is no underflow.
- FSM states: IDLE, BUSY, DROP.
  - IDLE + accepted head, routable: load port_sel/port_num, register the flit, go to BUSY. If the tail bit is also set (single-flit packet), stay IDLE instead; port_sel stays valid while that flit is held in out_valid.
  - IDLE + accepted head, unroutable: pulse err_unroutable, nothing is output. Go to DROP, or stay IDLE if the tail bit is set.
  - IDLE + accepted non-head: pulse err_orphan, flit discarded.
  - BUSY + accepted flit: forwarded on the locked port, whatever its head bit (a head bit in BUSY is treated as body). When the tail is accepted, go to IDLE.
  - DROP: every flit is accepted and discarded. When the tail is accepted, go to IDLE.
- port_sel/port_num:
  - Change only when a routable head is accepted.
  - Clear to 0 when the held tail flit transfers out and no new head is accepted in the same cycle.
  - A new head accepted in the same cycle the tail drains loads the new select directly.
- pkt_count: increments by 1 on each output transfer whose flit has the tail bit set, including single-flit packets. Wraps from all-ones to 0.
- out_flit and port_sel hold stable while out_valid=1 and out_ready[port_num]=0.
- The block ignores out_ready bits for unselected ports.

Test Plan:
- Reset, then a single-flit packet: head+tail, dest=1 → next cycle out_valid=1, port_sel=10'b0000000001, port_num=0. After transfer pkt_count=1 and port_sel=0.
- 3-flit packet to dest=10, out_ready[9] low for 2 cycles then high → port_sel=10'b1000000000 held throughout, in_ready=0 while stalled, all 3 flits delivered in order, state returns to IDLE.
- Head with dest=0, then dest=11 (each 2 flits) → err_unroutable pulses once per packet, out_valid stays 0, body/tail consumed (in_ready=1), pkt_count unchanged.
- Body flit (no head bit) in IDLE → err_orphan pulses 1 cycle, nothing output.
- Back-to-back packets dest=3 then dest=7 with all out_ready high → 1 flit/cycle, port_sel switches 0x004→0x040 in the cycle after the first tail, no bubble.
- Assert rst mid-packet (after head, before tail) → all outputs 0 next cycle. A subsequent packet routes correctly. Separately, pkt_count preloaded by 65535 packets wraps to 0 on the next tail.
